// File: rtl/bd_pkg.sv
// bd_pkg: widths, leaf codes and word types shared along the decoded BD word path.
package bd_pkg;
  localparam int NBDpayload = 32;
  localparam int NBDcode = 4;
  localparam int Ntag = 11;
  localparam int Nct = 9;
  localparam logic [NBDcode-1:0] TAG_LEAF_CODE = 4'd2;
  typedef struct packed {
    logic [NBDcode-1:0] leaf_code;
    logic [NBDpayload-1:0] payload;
  } bd_word_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;
  typedef enum logic {OTHER, TAG} grant_t;
  function automatic bd_word_t pack_tag(input logic [Ntag-1:0] tag, input logic [Nct-1:0] ct);
    pack_tag.leaf_code = TAG_LEAF_CODE;
    pack_tag.payload = {{(NBDpayload-Ntag-Nct){1'b0}}, ct, tag};
  endfunction
endpackage

// File: rtl/bd_tag_merge_if.sv
// bd_tag_merge_if: tag, other-word and merged BD channels of the tag merge block.
interface bd_tag_merge_if;
  import bd_pkg::*;
  logic tag_in_v;
  logic tag_in_a;
  logic [Ntag-1:0] tag_in_tag;
  logic [Nct-1:0] tag_in_ct;
  logic other_in_v;
  logic other_in_a;
  logic [NBDpayload-1:0] other_in_payload;
  logic [NBDcode-1:0] other_in_leaf_code;
  logic BD_out_v;
  logic BD_out_a;
  logic [NBDpayload-1:0] BD_out_payload;
  logic [NBDcode-1:0] BD_out_leaf_code;
  logic [31:0] tag_count;
  modport master (
    output tag_in_v, tag_in_tag, tag_in_ct, other_in_v, other_in_payload, other_in_leaf_code, BD_out_a,
    input tag_in_a, other_in_a, BD_out_v, BD_out_payload, BD_out_leaf_code, tag_count
  );
  modport slave (
    input tag_in_v, tag_in_tag, tag_in_ct, other_in_v, other_in_payload, other_in_leaf_code, BD_out_a,
    output tag_in_a, other_in_a, BD_out_v, BD_out_payload, BD_out_leaf_code, tag_count
  );
endinterface

// File: rtl/bd_word_fifo2.sv
// bd_word_fifo2: two-entry word buffer; the head is a register so out_d never depends on inputs.
module bd_word_fifo2 import bd_pkg::*; #(
  parameter int W = 36
) (
  input logic clk,
  input logic reset,
  input logic in_v,
  input logic [W-1:0] in_d,
  output logic in_a_nxt,
  output logic out_v,
  input logic out_a,
  output logic [W-1:0] out_d
);
  fifo_state_t state, state_nxt;
  logic [W-1:0] tail;
  logic push, pop;
  assign push = in_v && state != FULL;
  assign pop = out_v && out_a;
  assign out_v = state != EMPTY;
  // space seen by the producer next cycle, before knowing next cycle's pop
  assign in_a_nxt = state_nxt != FULL;
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: state_nxt = push ? ONE : EMPTY;
      ONE: state_nxt = push && !pop ? FULL : (!push && pop ? EMPTY : ONE);
      FULL: state_nxt = pop ? ONE : FULL;
      default: state_nxt = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      out_d <= '0;
      tail <= '0;
    end else begin
      state <= state_nxt;
      if (push && (state == EMPTY || pop))
        out_d <= in_d;
      else if (pop && state == FULL)
        out_d <= tail;
      if (push && state == ONE && !pop)
        tail <= in_d;
    end
  end
endmodule

// File: rtl/bd_tag_merge.sv
// bd_tag_merge: packs tag/count words under the tag leaf code and round-robin merges them
// with other decoded BD words into one stream through a two-entry output buffer.
module bd_tag_merge import bd_pkg::*; (
  input logic clk,
  input logic reset,
  bd_tag_merge_if.slave bus
);
  grant_t last_grant, last_grant_nxt;
  logic tag_x, other_x, space_nxt, tag_a_nxt, other_a_nxt;
  bd_word_t in_word, out_word;
  assign tag_x = bus.tag_in_v && bus.tag_in_a;
  assign other_x = bus.other_in_v && bus.other_in_a;
  assign in_word = tag_x ? pack_tag(bus.tag_in_tag, bus.tag_in_ct) : {bus.other_in_leaf_code, bus.other_in_payload};
  // held valids predict next cycle's requests, so the acks can be registered
  always_comb begin
    tag_a_nxt = space_nxt && bus.tag_in_v && (!bus.other_in_v || last_grant == OTHER);
    other_a_nxt = space_nxt && bus.other_in_v && !tag_a_nxt;
    last_grant_nxt = tag_a_nxt ? TAG : (other_a_nxt ? OTHER : last_grant);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.tag_in_a <= 1'b0;
      bus.other_in_a <= 1'b0;
      bus.tag_count <= '0;
      last_grant <= OTHER;
    end else begin
      bus.tag_in_a <= tag_a_nxt;
      bus.other_in_a <= other_a_nxt;
      bus.tag_count <= bus.tag_count + 32'(tag_x);
      last_grant <= last_grant_nxt;
    end
  end
  bd_word_fifo2 #(.W($bits(bd_word_t))) u_fifo (
    .clk(clk),
    .reset(reset),
    .in_v(tag_x || other_x),
    .in_d(in_word),
    .in_a_nxt(space_nxt),
    .out_v(bus.BD_out_v),
    .out_a(bus.BD_out_a),
    .out_d(out_word)
  );
  assign bus.BD_out_payload = out_word.payload;
  assign bus.BD_out_leaf_code = out_word.leaf_code;
endmodule

// File: doc/bd_tag_merge.md
# bd_tag_merge

Merges the tag/count stream (tag, ct) with the stream of other decoded BD words into one decoded BD-word stream bound for the BD encoder. Inverse of the tag split on the BD-to-FPGA path: tag words are packed into a payload under the tag leaf code, and the two inputs are fairly arbitrated. A two-entry output buffer keeps full throughput with registered acks.

## Interface
- NBDpayload, 32, payload width of a decoded BD word
- NBDcode, 4, leaf code width
- Ntag, 11, tag width
- Nct, 9, count width
- TAG_LEAF_CODE, 4'd2, leaf code stamped on packed tag words
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- tag_in_v / tag_in_a  in/out  1/1  tag channel valid / ack
- tag_in_tag, tag_in_ct  in  Ntag, Nct  tag and count
- other_in_v / other_in_a  in/out  1/1  other-word channel valid / ack
- other_in_payload, other_in_leaf_code  in  NBDpayload, NBDcode
- BD_out_v / BD_out_a  out/in  1/1  merged channel valid / ack
- BD_out_payload, BD_out_leaf_code  out  NBDpayload, NBDcode
- tag_count  out  32  count of tag words accepted since reset, wraps at 2^32

## Operation
- Handshake, all channels: transfer when v && a in the same cycle. Sources hold v and data stable until transfer; v does not depend on a.
- Tag packing: payload = {(NBDpayload-Ntag-Nct)'b0, ct, tag}; leaf_code = TAG_LEAF_CODE. Other words pass through unchanged, including any that carry TAG_LEAF_CODE.
- Arbitration: at most one input accepted per cycle, and only if the buffer has space after this cycle's output transfer.
- Round-robin pointer last_grant (reset: OTHER, so tag wins the first tie). When both inputs are valid, grant the one not granted last. When one is valid, grant it. last_grant updates only on a grant.
- Only the granted input sees a=1. The other input's a=0.
- Output buffer: 2-entry FIFO, states EMPTY, ONE, FULL.
  - EMPTY: grant sends the word to ONE.
  - ONE: grant without output transfer sends it to FULL. Grant with output transfer stays in ONE. Output transfer with no grant sends it to EMPTY.
  - FULL: no grant. Output transfer sends it to ONE.
- Words leave in grant order.
- tag_count increments on each tag transfer and wraps at 2^32.

## Timing
- Reset values: tag_in_a=0, other_in_a=0, BD_out_v=0, BD_out_payload=0, BD_out_leaf_code=0, tag_count=0, last_grant=OTHER, FIFO EMPTY.
- A reset assertion mid-operation drops all buffered words. Outputs go to reset values asynchronously.
- Input acks are registered, computed from the next-state space and next-state grant.
- Latency: a word accepted in cycle N has BD_out_v=1 in cycle N+1.
- Throughput: one word per cycle sustained while BD_out_a=1.
- Empty boundary: BD_out_v=0 exactly when the FIFO is EMPTY.
- Full boundary: in FULL, both input acks are 0 in the next cycle unless an output transfer occurs this cycle.
- An output transfer and a grant in the same cycle do not change occupancy. No word is lost or duplicated.
- No combinational path from any input v or data, or from BD_out_a, to any output.

## Structure
- Shared package (bd_pkg): NBDpayload, NBDcode, Ntag, Nct, leaf-code constants including TAG_LEAF_CODE, and a packed struct typedef for the decoded BD word {leaf_code, payload}.
- Sub-module bd_word_fifo2: the 2-entry FIFO, parameterised on word width, with an in/out v/a interface.
- Top-level module: arbiter, packing logic and tag_count.

## Test plan
- Tag only: tag=11'h5A5, ct=9'h1FF, BD_out_a held 1.
  - Required: BD_out_payload=32'h000FFDA5, BD_out_leaf_code=TAG_LEAF_CODE, one cycle after the tag transfer; tag_count=1.
- Both inputs continuously valid, BD_out_a=1, 20 cycles after reset.
  - Required: output alternates tag, other, tag, …, starting with tag.
  - Required: one word per cycle; tag_count=10.
- Backpressure: BD_out_a=0 with both inputs valid.
  - Required: exactly 2 words accepted, then both acks 0.
  - Raising BD_out_a: the 2 words drain in order, then acceptance resumes with no gap.
- Pass-through: other word, leaf_code=4'hB, payload=32'hDEADBEEF.
  - Required: emitted unchanged; tag_count unchanged.
- Reset mid-operation: assert reset low with the FIFO FULL.
  - Required: BD_out_v=0 immediately, tag_count=0.
  - Required: after release, the first tie is granted to tag.
- Random sources and sink, 10k words.
  - Required: a scoreboard shows each input's order is preserved, with no loss or duplication.
  - Required: tag_count equals the number of tags sent.
